sequence_bit_serializer: RTL and testbench

SEQUENCE_BIT_SERIALIZER -- requirements
Module: sequence_bit_serializer

---
 rtl/sequence_bit_serializer_pkg.sv | 15 +
 rtl/sequence_bit_serializer.sv | 101 ++++++++++
 tb/tb_sequence_bit_serializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_bit_serializer_pkg.sv
// Shared FSM encoding and sizing helpers for the sequence detector blocks.
// The serializer and the downstream detectors agree on these state values.
package sequence_bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_e;

    // Bit counter width; a 1-bit floor keeps the counter well formed.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sequence_bit_serializer.sv
// Parallel-to-serial converter with a one-entry holding register, feeding the
// serial bit stream x to a downstream sequence detector.
//
// state | meaning
// IDLE  | no word shifting, x = IDLE_BIT; loads the held word when one is waiting
// SHIFT | one bit per clock on x; on the last bit reloads from hold or returns to IDLE
module sequence_bit_serializer
    import sequence_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             busy,
    output logic             word_done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             last_bit;
    logic [WIDTH-1:0] shift_next;

    assign last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;

        // Handshake and load never coincide: accept needs hold empty, load needs it full.
        if (din_valid && !hold_valid_q) begin
            hold_d       = din;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    cnt_d        = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign din_ready = !hold_valid_q;
    assign busy      = (state_q == SHIFT);
    assign word_done = last_bit;
    assign x         = (state_q == SHIFT) ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                                          : IDLE_BIT;

endmodule

// File: tb/tb_sequence_bit_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one input
// stream; expected bit sequences are queued per handshake and popped by a monitor.
module tb_sequence_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic rdy_m, x_m, busy_m, wd_m;
    logic rdy_l, x_l, busy_l, wd_l;

    always #5 clk = ~clk;

    sequence_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .x(x_m), .busy(busy_m), .word_done(wd_m)
    );

    sequence_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .x(x_l), .busy(busy_l), .word_done(wd_l)
    );

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];
    int   wd_stamps[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   z_cnt = 0;
    logic [3:0] hist = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a word becomes 8 bits in transmit order, last one flagged.
    function automatic void push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            q_m.push_back('{b: w[7-i], last: (i == 7)});
            q_l.push_back('{b: w[i],   last: (i == 7)});
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy_m) begin
                if (q_m.size() == 0) begin
                    check1("unexpected_bit_msb", 1'b1, 1'b0);
                end else begin
                    e = q_m.pop_front();
                    check1("x_msb", x_m, e.b);
                    check1("word_done_msb", wd_m, e.last);
                    if (wd_m) wd_stamps.push_back(cyc);
                end
            end else begin
                check1("idle_x_msb", x_m, 1'b0);
                check1("idle_word_done_msb", wd_m, 1'b0);
            end
            if (busy_l) begin
                if (q_l.size() == 0) begin
                    check1("unexpected_bit_lsb", 1'b1, 1'b0);
                end else begin
                    e = q_l.pop_front();
                    check1("x_lsb", x_l, e.b);
                    check1("word_done_lsb", wd_l, e.last);
                end
            end else begin
                check1("idle_x_lsb", x_l, 1'b0);
                check1("idle_word_done_lsb", wd_l, 1'b0);
            end
        end
    end

    // Downstream overlapping 1101 detector on the LSB-first stream.
    always @(negedge clk) begin
        hist <= {hist[2:0], x_l};
        if ({hist[2:0], x_l} == 4'b1101) z_cnt <= z_cnt + 1;
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] w);
        bit   done = 1'b0;
        logic r;
        din       = w;
        din_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            r = rdy_m;
            @(posedge clk);
            if (r) begin
                push_word(w);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check1("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit idle = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clk);
            #1;
            idle = (q_m.size() == 0) && (q_l.size() == 0) && !busy_m && !busy_l;
        end
        check_int("drain_q_msb", q_m.size(), 0);
        check_int("drain_q_lsb", q_l.size(), 0);
        check1("drain_busy", busy_m | busy_l, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int z0;
        logic [7:0] a, b;

        #1;
        check1("rst_x", x_m, 1'b0);
        check1("rst_busy", busy_m, 1'b0);
        check1("rst_word_done", wd_m, 1'b0);
        check1("rst_din_ready", rdy_m, 1'b1);
        check1("rst_din_ready_lsb", rdy_l, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word 0xD0 with first-bit latency.
        send(8'hD0);
        din_valid = 1'b0;
        check1("latency_not_yet_busy", busy_m, 1'b0);
        @(negedge clk);
        check1("latency_first_busy", busy_m, 1'b1);
        check1("latency_first_bit", x_m, 1'b1);
        drain();

        // Back-to-back 0xDD, 0xB0: word_done pulses 8 cycles apart.
        n = wd_stamps.size();
        send(8'hDD);
        send(8'hB0);
        din_valid = 1'b0;
        drain();
        check_int("b2b_word_done_count", wd_stamps.size() - n, 2);
        if (wd_stamps.size() - n == 2)
            check_int("b2b_word_done_spacing", wd_stamps[n+1] - wd_stamps[n], 8);

        // din_valid held high over 4 words.
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom_range(0, 255)));
            check1("ready_low_when_full", rdy_m, 1'b0);
        end
        din_valid = 1'b0;
        drain();

        // Reset after the 3rd bit of a word while a second word is held.
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        send(a);
        send(b);
        din_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("midrst_x", x_m, 1'b0);
        check1("midrst_din_ready", rdy_m, 1'b1);
        check1("midrst_busy", busy_m, 1'b0);
        check1("midrst_word_done", wd_m, 1'b0);
        q_m.delete();
        q_l.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check1("post_rst_din_ready", rdy_m, 1'b1);

        // LSB-first 0x0B feeding the 1101 detector.
        z0 = z_cnt;
        send(8'h0B);
        din_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check_int("detector_z_count", z_cnt - z0, 1);

        // Random words with random gaps.
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) != 0) begin
                din_valid = 1'b0;
                repeat ($urandom_range(0, 10)) @(negedge clk);
            end
        end
        din_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
